pkt_fifo_wr_ctrl: RTL
=====================

// Module: pkt_fifo_wr_ctrl
// PURPOSE
//   Write-side packet controller for the async packet FIFO. Takes a non-backpressured
//   sop/eop word stream in the WrClock domain and drives the FIFO's WrEn/WrEop/Data.
//   Packets are admitted or dropped whole, based on AlmostFull sampled at SOP.
//   Overlength packets are truncated at c_MAX_LEN. Framing errors are absorbed so the
//   reader only ever sees committed packets.
// PARAMETERS
//   c_DATA_WIDTH  10    width of in_data / Data
//   c_MAX_LEN     64    max words per packet, 1..2**c_LEN_WIDTH-1
//   c_LEN_WIDTH   8     width of internal word-length counter
//   c_CNT_WIDTH   16    width of statistics counters
// PORTS
//   WrClock     in   1             write-domain clock
//   Reset       in   1             async, active-high
//   in_valid    in   1             input word valid
//   in_sop      in   1             first word of packet; qualified by in_valid
//   in_eop      in   1             last word of packet; qualified by in_valid
//   in_data     in   c_DATA_WIDTH  input word
//   AlmostFull  in   1             FIFO almost-full flag, same clock
//   WrEn        out  1             FIFO write enable
//   WrEop       out  1             FIFO commit; with WrEn commits this word too
//   Data        out  c_DATA_WIDTH  FIFO write data
//   pkt_cnt     out  c_CNT_WIDTH   packets committed, truncated ones included
//   drop_cnt    out  c_CNT_WIDTH   packets dropped (AlmostFull or framing error)
//   trunc_cnt   out  c_CNT_WIDTH   packets truncated at c_MAX_LEN
//   busy        out  1             FSM not in IDLE
// BEHAVIOUR
//   Reset (async, active-high; clock WrClock): all outputs 0; FSM=IDLE; len=0.
//   All outputs are registered. Latency in_* -> WrEn/WrEop/Data is exactly 1 cycle.
//   States and transitions:
//   - IDLE, valid&sop&!AlmostFull: write word, len=1.
//       With eop: WrEop=1, pkt_cnt++, stay IDLE. Without eop: -> PASS.
//   - IDLE, valid&sop&AlmostFull: no write, drop_cnt++.
//       -> DROP, or stay IDLE if eop is also set.
//   - IDLE, valid without sop: word ignored, no counter change.
//   - PASS, valid&!sop: write word, len++.
//       eop -> WrEop=1, pkt_cnt++, -> IDLE.
//       else if len+1==c_MAX_LEN -> WrEop=1, pkt_cnt++, trunc_cnt++, -> TRUNC.
//   - PASS, valid&sop (missing eop): new word not written.
//       Emit WrEn=0, WrEop=1 to commit the previous packet: pkt_cnt++, drop_cnt++.
//       -> DROP, or IDLE if eop is also set.
//   - DROP/TRUNC: all words discarded until valid&eop -> IDLE.
//       valid&sop in DROP/TRUNC is handled as in IDLE on that same cycle
//       (admission check, new packet starts).
//   AlmostFull is evaluated only at SOP; mid-packet changes are ignored.
//   Integration rule: FIFO depth - c_AFULL_FLAG >= c_MAX_LEN.
//   in_valid=0 in any state: no write, state held.
//   Counters saturate at all-ones and do not wrap. len is never compared beyond c_MAX_LEN.
//   Reset mid-packet: partial packet abandoned. The FIFO shares Reset, so no
//   uncommitted words survive.
//   No output X: Data holds its last value when WrEn=0.
// TESTING
//   1. 5-word packet, AlmostFull=0 -> WrEn 5 cycles starting 1 cycle late;
//      WrEop only on word 5; pkt_cnt=1.
//   2. Single word, sop&eop -> one cycle with WrEn=WrEop=1; FSM stays IDLE; busy never 1.
//   3. AlmostFull=1 at SOP of a 4-word packet, deasserted on word 2
//      -> no WrEn; drop_cnt=1; next packet admitted.
//   4. 70-word packet, c_MAX_LEN=64 -> 64 writes, WrEop on word 64,
//      words 65-70 discarded; trunc_cnt=1, pkt_cnt=1.
//   5. 3 words without eop, then a new sop -> WrEn=0/WrEop=1 pulse;
//      new packet dropped to its eop; pkt_cnt=1, drop_cnt=1.
//   6. Reset asserted on word 3 of 6 -> outputs 0 immediately; words 4-6 ignored (no sop);
//      next packet passes normally; drop_cnt forced to all-ones stays saturated.

Source files
------------

// File: rtl/pkt_fifo_wr_ctrl.sv
// Write-side packet controller for the async packet FIFO.
// Admits or drops whole packets, truncates overlength ones, absorbs framing errors.
module pkt_fifo_wr_ctrl #(
  parameter int c_DATA_WIDTH = 10,
  parameter int c_MAX_LEN    = 64,
  parameter int c_LEN_WIDTH  = 8,
  parameter int c_CNT_WIDTH  = 16
) (
  input  logic                    WrClock,
  input  logic                    Reset,
  input  logic                    in_valid,
  input  logic                    in_sop,
  input  logic                    in_eop,
  input  logic [c_DATA_WIDTH-1:0] in_data,
  input  logic                    AlmostFull,
  output logic                    WrEn,
  output logic                    WrEop,
  output logic [c_DATA_WIDTH-1:0] Data,
  output logic [c_CNT_WIDTH-1:0]  pkt_cnt,
  output logic [c_CNT_WIDTH-1:0]  drop_cnt,
  output logic [c_CNT_WIDTH-1:0]  trunc_cnt,
  output logic                    busy
);

  typedef enum logic [1:0] {
    IDLE,
    PASS,
    DROP,
    TRUNC
  } state_t;

  localparam logic [c_LEN_WIDTH-1:0] c_ONE = c_LEN_WIDTH'(1);
  localparam logic [c_LEN_WIDTH-1:0] c_MAX = c_LEN_WIDTH'(c_MAX_LEN);
  localparam logic [c_CNT_WIDTH-1:0] c_CNT_ONE = c_CNT_WIDTH'(1);

  state_t                 state_q;
  state_t                 state_d;
  logic [c_LEN_WIDTH-1:0] len_q;
  logic [c_LEN_WIDTH-1:0] len_d;
  logic [c_LEN_WIDTH-1:0] len_inc;
  logic                   wr_en_d;
  logic                   wr_eop_d;
  logic                   pkt_inc;
  logic                   drop_inc;
  logic                   trunc_inc;

  assign len_inc = len_q + c_ONE;

  function automatic logic [c_CNT_WIDTH-1:0] sat_inc(
    input logic [c_CNT_WIDTH-1:0] v,
    input logic                   en
  );
    return (en && (v != '1)) ? v + c_CNT_ONE : v;
  endfunction

  // Next-state and next-output decode; a sop outside PASS is always an admission check
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    wr_en_d   = 1'b0;
    wr_eop_d  = 1'b0;
    pkt_inc   = 1'b0;
    drop_inc  = 1'b0;
    trunc_inc = 1'b0;
    if (in_valid) begin
      if (state_q == PASS) begin
        if (in_sop) begin
          wr_eop_d = 1'b1;
          pkt_inc  = 1'b1;
          drop_inc = 1'b1;
          len_d    = '0;
          state_d  = in_eop ? IDLE : DROP;
        end else begin
          wr_en_d = 1'b1;
          len_d   = len_inc;
          if (in_eop) begin
            wr_eop_d = 1'b1;
            pkt_inc  = 1'b1;
            state_d  = IDLE;
          end else if (len_inc == c_MAX) begin
            wr_eop_d  = 1'b1;
            pkt_inc   = 1'b1;
            trunc_inc = 1'b1;
            state_d   = TRUNC;
          end
        end
      end else if (in_sop) begin
        if (AlmostFull) begin
          drop_inc = 1'b1;
          len_d    = '0;
          state_d  = in_eop ? IDLE : DROP;
        end else begin
          wr_en_d = 1'b1;
          len_d   = c_ONE;
          if (in_eop) begin
            wr_eop_d = 1'b1;
            pkt_inc  = 1'b1;
            state_d  = IDLE;
          end else if (c_ONE == c_MAX) begin
            wr_eop_d  = 1'b1;
            pkt_inc   = 1'b1;
            trunc_inc = 1'b1;
            state_d   = TRUNC;
          end else begin
            state_d = PASS;
          end
        end
      end else if (in_eop) begin
        state_d = IDLE;
      end
    end
  end

  // Registered state, FIFO write port and saturating statistics
  always_ff @(posedge WrClock or posedge Reset) begin
    if (Reset) begin
      state_q   <= IDLE;
      len_q     <= '0;
      WrEn      <= 1'b0;
      WrEop     <= 1'b0;
      Data      <= '0;
      pkt_cnt   <= '0;
      drop_cnt  <= '0;
      trunc_cnt <= '0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      WrEn      <= wr_en_d;
      WrEop     <= wr_eop_d;
      if (wr_en_d) Data <= in_data;
      pkt_cnt   <= sat_inc(pkt_cnt, pkt_inc);
      drop_cnt  <= sat_inc(drop_cnt, drop_inc);
      trunc_cnt <= sat_inc(trunc_cnt, trunc_inc);
      busy      <= (state_d != IDLE);
    end
  end

endmodule
